// File: rtl/reg_cmd_pkg.sv
// Shared widths, FSM state codes and command/response record types
// for the reg_ctrl command master.
package reg_cmd_pkg;

  localparam int CMD_ADDR_W = 8;
  localparam int CMD_DATA_W = 16;
  localparam int CMD_ACC_W  = 2;
  localparam int CMD_FUNC_W = 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  typedef struct packed {
    logic                  wr;
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] wdata;
    logic [CMD_ACC_W-1:0]  acc;
    logic [CMD_FUNC_W-1:0] func;
  } cmd_t;

  typedef struct packed {
    logic                  wr;
    logic [CMD_DATA_W-1:0] rdata;
    logic                  err;
  } rsp_t;

endpackage

// File: rtl/reg_cmd_fifo.sv
// Synchronous command FIFO with first-word-fall-through read port;
// a push while full or a pop while empty is ignored.
module reg_cmd_fifo
  import reg_cmd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  cmd_t                   i_cmd,
  output cmd_t                   o_cmd,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int PTR_W = $clog2(DEPTH);

  cmd_t             r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_cmd   = r_mem[r_rptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_cmd;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
    end
  end

endmodule

// File: rtl/reg_cmd_master.sv
// Queues host commands and issues them to reg_ctrl one at a time,
// returning one response per command (err=1 when reg_ctrl never answers).
//   state    | meaning
//   ST_IDLE  | waiting for a queued command
//   ST_ISSUE | sel high, waiting for ready or timeout
//   ST_RESP  | response held until the host accepts it
module reg_cmd_master
  import reg_cmd_pkg::*;
#(
  parameter int ADDR_W  = CMD_ADDR_W,
  parameter int DATA_W  = CMD_DATA_W,
  parameter int ACC_W   = CMD_ACC_W,
  parameter int FUNC_W  = CMD_FUNC_W,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_wr,
  input  logic [ADDR_W-1:0]      cmd_addr,
  input  logic [DATA_W-1:0]      cmd_wdata,
  input  logic [ACC_W-1:0]       cmd_acc,
  input  logic [FUNC_W-1:0]      cmd_func,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_wr,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   rsp_err,
  output logic                   sel,
  output logic                   wr,
  output logic [ADDR_W-1:0]      addr,
  output logic [DATA_W-1:0]      wdata,
  output logic [ACC_W-1:0]       acc,
  output logic [FUNC_W-1:0]      func,
  input  logic [DATA_W-1:0]      rdata,
  input  logic                   ready,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
);
  localparam int               CNT_W   = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  cmd_t             r_cmd;
  rsp_t             r_rsp;
  logic             r_sel;
  logic             r_rsp_valid;
  cmd_t             w_cmd_in;
  cmd_t             w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;

  // cmd_ready looks only at full, so a pop in the same cycle never frees a slot early.
  assign cmd_ready = !w_full && !rst;
  assign w_push    = cmd_valid && cmd_ready;
  assign w_pop     = (r_state == ST_IDLE) && !w_empty;
  assign w_cmd_in  = {cmd_wr, cmd_addr, cmd_wdata, cmd_acc, cmd_func};

  reg_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_cmd   (w_cmd_in),
    .o_cmd   (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_cmd       <= '0;
      r_sel       <= 1'b0;
      r_rsp       <= '0;
      r_rsp_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_cmd   <= w_head;
            r_sel   <= 1'b1;
            r_cnt   <= '0;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // ready is checked first so a completion on the last allowed cycle still counts.
          if (ready) begin
            r_sel       <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp.wr    <= r_cmd.wr;
            r_rsp.rdata <= r_cmd.wr ? '0 : rdata;
            r_rsp.err   <= 1'b0;
            r_state     <= ST_RESP;
          end else if (r_cnt == TO_LAST) begin
            r_sel       <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp.wr    <= r_cmd.wr;
            r_rsp.rdata <= '0;
            r_rsp.err   <= 1'b1;
            r_state     <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign sel       = r_sel;
  assign wr        = r_cmd.wr;
  assign addr      = r_cmd.addr;
  assign wdata     = r_cmd.wdata;
  assign acc       = r_cmd.acc;
  assign func      = r_cmd.func;
  assign rsp_valid = r_rsp_valid;
  assign rsp_wr    = r_rsp.wr;
  assign rsp_rdata = r_rsp.rdata;
  assign rsp_err   = r_rsp.err;
  assign busy      = (r_state != ST_IDLE) || !w_empty;

endmodule

// File: tb/tb_reg_cmd_master.sv
// Self-checking bench for reg_cmd_master: a behavioural reg_ctrl responder with
// per-command latency, and a register-file model predicting every response.
module tb_reg_cmd_master;
  localparam int TIMEOUT = 64;
  localparam int DEPTH   = 4;
  localparam int NEVER   = 100000;

  typedef struct packed {
    logic        wr;
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_wr = 1'b0;
  logic [7:0]  cmd_addr = '0;
  logic [15:0] cmd_wdata = '0;
  logic [1:0]  cmd_acc = '0;
  logic [1:0]  cmd_func = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_wr;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        sel;
  logic        wr;
  logic [7:0]  addr;
  logic [15:0] wdata;
  logic [1:0]  acc;
  logic [1:0]  func;
  logic [15:0] rdata;
  logic        ready;
  logic        busy;
  logic [2:0]  fifo_count;

  int          errors = 0;
  int          checks = 0;

  // model state (written only by the stimulus process)
  exp_t        exp_q[$];
  logic [15:0] mdl_mem[int];
  int          lat_arr[int];
  int          n_pushed = 0;
  bit          spurious_ready = 1'b0;

  // responder state (written only by the responder process)
  logic [15:0] regmem[int];
  int          sel_cyc = 0;
  int          lat_cur = 0;
  int          issue_idx = 0;
  logic [28:0] fld_snap = '0;
  bit          stab_bad = 1'b0;

  reg_cmd_master #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_acc(cmd_acc), .cmd_func(cmd_func),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wr(rsp_wr), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .sel(sel), .wr(wr), .addr(addr), .wdata(wdata), .acc(acc), .func(func),
    .rdata(rdata), .ready(ready), .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] init_val(int a);
    return 16'(a * 307 + 49374);
  endfunction

  // reg_ctrl stand-in: ready arrives on sel cycle number lat (0-based) of each transaction.
  always @(negedge clk) begin
    if (rst) issue_idx = n_pushed;
    if (rst || !sel) begin
      sel_cyc = 0;
      ready   = spurious_ready && !rst;
      rdata   = 16'($urandom);
    end else begin
      if (sel_cyc == 0) begin
        lat_cur  = lat_arr.exists(issue_idx) ? lat_arr[issue_idx] : NEVER;
        issue_idx++;
        fld_snap = {wr, addr, wdata, acc, func};
      end else if ({wr, addr, wdata, acc, func} !== fld_snap) begin
        stab_bad = 1'b1;
      end
      ready = (sel_cyc == lat_cur);
      rdata = 16'($urandom);
      if (ready && !wr) rdata = regmem.exists(int'(addr)) ? regmem[int'(addr)] : init_val(int'(addr));
      if (ready && wr) regmem[int'(addr)] = wdata;
      sel_cyc++;
    end
  end

  // Reference: in-order register file; a command whose latency reaches TIMEOUT aborts.
  function automatic void model_push(logic w, logic [7:0] a, logic [15:0] d, int lat);
    exp_t x;
    x.wr    = w;
    x.err   = (lat >= TIMEOUT);
    x.rdata = 16'h0;
    if (!w && !x.err) x.rdata = mdl_mem.exists(int'(a)) ? mdl_mem[int'(a)] : init_val(int'(a));
    if (w && !x.err) mdl_mem[int'(a)] = d;
    exp_q.push_back(x);
    lat_arr[n_pushed] = lat;
    n_pushed++;
  endfunction

  task automatic push_cmd(input logic w, input logic [7:0] a, input logic [15:0] d,
                          input logic [1:0] ac, input logic [1:0] fn, input int lat);
    bit done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      cmd_valid = 1'b1; cmd_wr = w; cmd_addr = a; cmd_wdata = d; cmd_acc = ac; cmd_func = fn;
      if (cmd_ready === 1'b1) begin
        @(posedge clk);
        done = 1'b1;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL push_accept: cmd_ready never observed high for addr %h", a);
    end else begin
      model_push(w, a, d, lat);
    end
    #1 cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(output logic w, output logic [15:0] d, output logic e,
                         output bit got, output exp_t x);
    got = 1'b0; w = 1'b0; d = '0; e = 1'b0; x = '0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        w = rsp_wr; d = rsp_rdata; e = rsp_err; got = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
      end
    end
    if (got && exp_q.size() > 0) x = exp_q.pop_front();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({sel, wr, addr, wdata, acc, func} !== 29'h0) begin
      errors++; $display("FAIL reset_ctrl: observed %h required 0", {sel, wr, addr, wdata, acc, func});
    end
    checks++;
    if ({rsp_valid, rsp_wr, rsp_rdata, rsp_err} !== 19'h0) begin
      errors++; $display("FAIL reset_rsp: observed %h required 0", {rsp_valid, rsp_wr, rsp_rdata, rsp_err});
    end
    checks++;
    if ({cmd_ready, busy, fifo_count} !== 5'h0) begin
      errors++; $display("FAIL reset_status: observed cmd_ready=%b busy=%b count=%0d required 0 0 0", cmd_ready, busy, fifo_count);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release: observed cmd_ready=%b required 1", cmd_ready);
    end
  endtask

  task automatic test_single_write();
    logic w, e; logic [15:0] d; bit got; exp_t x; int n;
    push_cmd(1'b1, 8'h04, 16'hA5A5, 2'd1, 2'd2, 2);
    checks++;
    if (sel !== 1'b0 || fifo_count !== 3'd1 || busy !== 1'b1) begin
      errors++; $display("FAIL sw_pushed: observed sel=%b count=%0d busy=%b required 0 1 1", sel, fifo_count, busy);
    end
    @(posedge clk); #1;
    checks++;
    if ({sel, wr, addr, wdata, acc, func} !== {1'b1, 1'b1, 8'h04, 16'hA5A5, 2'd1, 2'd2}) begin
      errors++; $display("FAIL sw_issue: observed %h required %h", {sel, wr, addr, wdata, acc, func},
                         {1'b1, 1'b1, 8'h04, 16'hA5A5, 2'd1, 2'd2});
    end
    n = 0;
    while (sel === 1'b1 && n < 200) begin n++; @(posedge clk); #1; end
    checks++;
    if (n != 3 || rsp_valid !== 1'b1) begin
      errors++; $display("FAIL sw_sel_len: observed %0d cycles rsp_valid=%b required 3 cycles rsp_valid=1", n, rsp_valid);
    end
    get_rsp(w, d, e, got, x);
    checks++;
    if (!got || {w, d, e} !== x || x !== {1'b1, 16'h0, 1'b0}) begin
      errors++; $display("FAIL sw_rsp: observed got=%0d wr=%b rdata=%h err=%b required wr=1 rdata=0000 err=0", got, w, d, e);
    end
  endtask

  task automatic test_write_read();
    logic w, e; logic [15:0] d; bit got; exp_t x;
    push_cmd(1'b1, 8'h08, 16'h1234, 2'($urandom), 2'($urandom), 1);
    push_cmd(1'b0, 8'h08, 16'($urandom), 2'($urandom), 2'($urandom), 3);
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (sel !== 1'b0 || rsp_valid !== 1'b1 || fifo_count !== 3'd1) begin
      errors++; $display("FAIL wr_hold: observed sel=%b rsp_valid=%b count=%0d required 0 1 1", sel, rsp_valid, fifo_count);
    end
    get_rsp(w, d, e, got, x);
    checks++;
    if (!got || {w, d, e} !== x) begin
      errors++; $display("FAIL wr_rsp_write: observed got=%0d %b %h %b required %b %h %b", got, w, d, e, x.wr, x.rdata, x.err);
    end
    checks++;
    if (sel !== 1'b0) begin
      errors++; $display("FAIL wr_gap: observed sel=%b on accept edge required 0", sel);
    end
    @(posedge clk); #1;
    checks++;
    if (sel !== 1'b1 || wr !== 1'b0 || addr !== 8'h08) begin
      errors++; $display("FAIL wr_second_issue: observed sel=%b wr=%b addr=%h required 1 0 08", sel, wr, addr);
    end
    get_rsp(w, d, e, got, x);
    checks++;
    if (!got || {w, d, e} !== x || d !== 16'h1234) begin
      errors++; $display("FAIL wr_rsp_read: observed got=%0d %b %h %b required 0 1234 0", got, w, d, e);
    end
  endtask

  task automatic test_backpressure();
    logic w, e; logic [15:0] d; bit got; exp_t x; logic [17:0] held;
    for (int i = 0; i < 5; i++)
      push_cmd(1'($urandom), 8'($urandom_range(0, 15)), 16'($urandom), 2'($urandom), 2'($urandom),
               int'($urandom_range(0, 4)));
    repeat (15) @(posedge clk);
    #1;
    checks++;
    if (fifo_count !== 3'd4 || cmd_ready !== 1'b0 || rsp_valid !== 1'b1) begin
      errors++; $display("FAIL bp_full: observed count=%0d cmd_ready=%b rsp_valid=%b required 4 0 1", fifo_count, cmd_ready, rsp_valid);
    end
    held = {rsp_wr, rsp_rdata, rsp_err};
    spurious_ready = 1'b1;
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 8'h77; cmd_wdata = 16'($urandom);
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if ({rsp_valid, rsp_wr, rsp_rdata, rsp_err} !== {1'b1, held}) begin
      errors++; $display("FAIL bp_hold: observed %h required %h", {rsp_valid, rsp_wr, rsp_rdata, rsp_err}, {1'b1, held});
    end
    checks++;
    if (fifo_count !== 3'd4 || sel !== 1'b0) begin
      errors++; $display("FAIL bp_refuse: observed count=%0d sel=%b required 4 0", fifo_count, sel);
    end
    cmd_valid = 1'b0;
    spurious_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k == 1)
        push_cmd(1'b0, 8'($urandom_range(0, 15)), 16'h0, 2'($urandom), 2'($urandom), 2);
      get_rsp(w, d, e, got, x);
      checks++;
      if (!got || {w, d, e} !== x) begin
        errors++; $display("FAIL bp_rsp%0d: observed got=%0d %b %h %b required %b %h %b", k, got, w, d, e, x.wr, x.rdata, x.err);
      end
    end
  endtask

  task automatic test_timeout();
    logic w, e; logic [15:0] d; bit got; exp_t x; int n;
    push_cmd(1'b0, 8'hFF, 16'h0, 2'($urandom), 2'($urandom), NEVER);
    push_cmd(1'b1, 8'h10, 16'($urandom), 2'($urandom), 2'($urandom), 1);
    n = 0;
    while (sel !== 1'b1 && n < 10) begin n++; @(posedge clk); #1; end
    n = 0;
    while (sel === 1'b1 && n < 200) begin n++; @(posedge clk); #1; end
    checks++;
    if (n != TIMEOUT) begin
      errors++; $display("FAIL to_sel_len: observed %0d sel cycles required %0d", n, TIMEOUT);
    end
    for (int k = 0; k < 2; k++) begin
      get_rsp(w, d, e, got, x);
      checks++;
      if (!got || {w, d, e} !== x) begin
        errors++; $display("FAIL to_rsp%0d: observed got=%0d %b %h %b required %b %h %b", k, got, w, d, e, x.wr, x.rdata, x.err);
      end
    end
  endtask

  task automatic test_timeout_boundary();
    logic w, e; logic [15:0] d; bit got; exp_t x;
    push_cmd(1'b0, 8'h20, 16'h0, 2'($urandom), 2'($urandom), TIMEOUT - 1);
    push_cmd(1'b1, 8'h21, 16'($urandom), 2'($urandom), 2'($urandom), TIMEOUT);
    push_cmd(1'b0, 8'h21, 16'h0, 2'($urandom), 2'($urandom), 0);
    for (int k = 0; k < 3; k++) begin
      get_rsp(w, d, e, got, x);
      checks++;
      if (!got || {w, d, e} !== x) begin
        errors++; $display("FAIL tb_rsp%0d: observed got=%0d %b %h %b required %b %h %b", k, got, w, d, e, x.wr, x.rdata, x.err);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic w, e; logic [15:0] d; bit got; exp_t x; bit seen;
    push_cmd(1'b0, 8'h30, 16'h0, 2'($urandom), 2'($urandom), NEVER);
    push_cmd(1'b0, 8'h31, 16'h0, 2'($urandom), 2'($urandom), 1);
    push_cmd(1'b0, 8'h32, 16'h0, 2'($urandom), 2'($urandom), 1);
    checks++;
    if (sel !== 1'b1 || fifo_count !== 3'd2) begin
      errors++; $display("FAIL rm_setup: observed sel=%b count=%0d required 1 2", sel, fifo_count);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({sel, wr, addr, wdata, acc, func, rsp_valid, rsp_wr, rsp_rdata, rsp_err} !== 48'h0) begin
      errors++; $display("FAIL rm_outputs: observed %h required 0",
                         {sel, wr, addr, wdata, acc, func, rsp_valid, rsp_wr, rsp_rdata, rsp_err});
    end
    checks++;
    if ({cmd_ready, busy, fifo_count} !== 5'h0) begin
      errors++; $display("FAIL rm_status: observed cmd_ready=%b busy=%b count=%0d required 0 0 0", cmd_ready, busy, fifo_count);
    end
    rst = 1'b0;
    exp_q.delete();
    spurious_ready = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (sel !== 1'b0 || rsp_valid !== 1'b0) seen = 1'b1;
    end
    spurious_ready = 1'b0;
    checks++;
    if (seen) begin
      errors++; $display("FAIL rm_quiet: observed activity after reset required none");
    end
    push_cmd(1'b1, 8'h33, 16'($urandom), 2'($urandom), 2'($urandom), 0);
    @(posedge clk); #1;
    checks++;
    if (sel !== 1'b1 || addr !== 8'h33) begin
      errors++; $display("FAIL rm_fresh_issue: observed sel=%b addr=%h required 1 33", sel, addr);
    end
    get_rsp(w, d, e, got, x);
    checks++;
    if (!got || {w, d, e} !== x) begin
      errors++; $display("FAIL rm_rsp: observed got=%0d %b %h %b required %b %h %b", got, w, d, e, x.wr, x.rdata, x.err);
    end
  endtask

  task automatic test_random();
    logic w, e; logic [15:0] d; bit got; exp_t x; int pushed; int lat;
    pushed = 0;
    for (int s = 0; s < 200 && (pushed < 24 || exp_q.size() > 0); s++) begin
      if (pushed < 24 && exp_q.size() < 4 && (exp_q.size() == 0 || $urandom_range(0, 1) == 1)) begin
        lat = ($urandom_range(0, 9) == 0) ? TIMEOUT + int'($urandom_range(0, 3)) : int'($urandom_range(0, 5));
        push_cmd(1'($urandom), 8'($urandom_range(0, 15)), 16'($urandom), 2'($urandom), 2'($urandom), lat);
        pushed++;
      end else begin
        get_rsp(w, d, e, got, x);
        checks++;
        if (!got || {w, d, e} !== x) begin
          errors++; $display("FAIL rand_rsp: observed got=%0d %b %h %b required %b %h %b", got, w, d, e, x.wr, x.rdata, x.err);
        end
        if (!got) break;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_write_read();
    test_backpressure();
    test_timeout();
    test_timeout_boundary();
    test_reset_mid();
    test_random();
    checks++;
    if (stab_bad) begin
      errors++; $display("FAIL field_stable: observed reg_ctrl fields changing while sel high required stable");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no completion required finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/reg_cmd_master.md
Name: reg_cmd_master

Overview:
- Upstream command source for the register controller; consumes host commands and drives reg_ctrl's addr/sel/wr/acc/func/wdata port.
- Buffers host commands in a small FIFO and issues them one at a time, honouring reg_ctrl's ready.
- Returns one response per command (read data or write acknowledge) with an error flag on timeout.
- Lets the bench and higher-level agents stream traffic without hand-driving reg_ctrl pins.

Parameters:
ADDR_W, 8, address width; must equal reg_ctrl addr width
DATA_W, 16, data width; must equal reg_ctrl wdata/rdata width
ACC_W, 2, access-type field width, forwarded unchanged
FUNC_W, 2, function field width, forwarded unchanged
DEPTH, 4, command FIFO entries; power of 2, at least 2
TIMEOUT, 64, max cycles sel may stay high without ready before abort; at least 2

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
cmd_valid  in  1  host command valid
cmd_ready  out  1  FIFO can accept (= !full and !rst)
cmd_wr  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  target address
cmd_wdata  in  DATA_W  write data (ignored for reads)
cmd_acc  in  ACC_W  access field
cmd_func  in  FUNC_W  function field
rsp_valid  out  1  response valid
rsp_ready  in  1  host accepts response
rsp_wr  out  1  echoes command type
rsp_rdata  out  DATA_W  captured rdata for reads; 0 for writes and errors
rsp_err  out  1  1 = command aborted by timeout
sel  out  1  to reg_ctrl
wr  out  1  to reg_ctrl
addr  out  ADDR_W  to reg_ctrl
wdata  out  DATA_W  to reg_ctrl
acc  out  ACC_W  to reg_ctrl
func  out  FUNC_W  to reg_ctrl
rdata  in  DATA_W  from reg_ctrl, valid in the cycle ready=1 for a read
ready  in  1  from reg_ctrl, completion strobe
busy  out  1  state != IDLE or FIFO non-empty
fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (clk edge with rst=1):
  - Clear FIFO, state=IDLE, timeout counter=0.
  - Registered outputs go to 0: sel, wr, addr, wdata, acc, func, rsp_valid, rsp_wr, rsp_rdata, rsp_err.
  - cmd_ready=0 while rst=1. busy=0 and fifo_count=0 after the edge.
  - A reset mid-transaction drops sel at that edge with no response; queued commands are lost.
- FIFO push: cmd_valid&cmd_ready at an edge. Pop: only in IDLE when non-empty.
- Simultaneous push and pop when full: the push is refused, because cmd_ready is derived from full before the pop.
- Pointers wrap modulo DEPTH.
- IDLE:
  - If FIFO is non-empty, pop the head, register its fields onto addr/wr/wdata/acc/func, set sel=1, clear the timeout counter, go to ISSUE.
  - A command pushed into an empty FIFO at edge N appears on sel at edge N+1 (one-cycle latency minimum).
- ISSUE:
  - sel and all fields stay stable until the transaction completes.
  - At each edge with ready=1, capture rdata if wr=0 (else capture 0), set sel=0, rsp_valid=1, rsp_err=0, rsp_wr=wr, go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 with no ready, set sel=0, rsp_valid=1, rsp_err=1, rsp_rdata=0, go to RESP.
  - A ready that arrives in the same cycle as the timeout wins: it is a normal completion.
- RESP:
  - rsp_* held stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_valid&rsp_ready, clear rsp_valid, go to IDLE.
  - The next command issues no earlier than the edge after the one in which the response is accepted. Exactly one outstanding transaction at a time.
- ready while sel=0 (IDLE/RESP): ignored.
- Commands are not reordered or merged; responses come back in command order.
- FIFO continues accepting commands in ISSUE and RESP.
- busy is combinational from state and occupancy.

Decomposition:
- Package reg_cmd_pkg:
  - width defaults
  - state enum {IDLE, ISSUE, RESP}
  - packed struct cmd_t {wr, addr, wdata, acc, func}
  - packed struct rsp_t {wr, rdata, err}
- Sub-module reg_cmd_fifo: synchronous FIFO of cmd_t with push/pop/full/empty/count, parameterised by DEPTH.
- reg_cmd_master holds the FSM, timeout counter and output registers.

Test Plan:
1. Single write: push wr=1, addr=0x04, wdata=0xA5A5, acc=1, func=2. reg_ctrl asserts ready 2 cycles after sel. Expect sel high for exactly 3 cycles with stable fields, then rsp_valid=1, rsp_wr=1, rsp_err=0, rsp_rdata=0.
2. Write-then-read: write 0x1234 to addr 0x08, then read addr 0x08. Expect the second sel to rise only after the first response is accepted, and the read response rsp_rdata=0x1234.
3. Back-pressure and full:
   - Hold rsp_ready=0, push 6 commands with DEPTH=4.
   - Expect cmd_ready=0 once fifo_count=4 (one command in flight).
   - Expect rsp_* stable while held.
   - Release rsp_ready: all responses arrive in order.
4. Timeout: reg_ctrl never asserts ready on a read to addr 0xFF. Expect sel to fall after TIMEOUT=64 cycles, then rsp_err=1 and rsp_rdata=0. The next queued command then completes normally.
5. Reset mid-operation: raise rst for 1 cycle while in ISSUE with 2 commands queued. Expect all outputs 0 at that edge, fifo_count=0, and no responses afterwards. A fresh command after rst=0 issues with 1-cycle latency.
6. Ready on the timeout boundary: ready=1 exactly on the 64th sel cycle. Expect a normal completion with rsp_err=0 and valid rdata.
